// File: rtl/sram_cmd_sequencer_pkg.sv
// Shared types and defaults for the JTAG-to-SRAM command sequencer.
package sram_cmd_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } seq_state_t;

    typedef logic [2:0] lat_cnt_t;

endpackage

// File: rtl/sram_cmd_sequencer_req_sync.sv
// Multi-flop synchroniser bringing a tck-domain request level into clk.
module req_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic aclr,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the flop chain
    always_ff @(posedge clk) begin
        if (aclr) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sram_cmd_sequencer.sv
// Turns level-based JTAG write/read requests into single-cycle SRAM strobes
// and returns read data over a 4-phase req/ack handshake.
module sram_cmd_sequencer
    import sram_cmd_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RD_LAT      = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              req_wr,
    input  logic              req_rd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data_out,
    input  logic [DATA_W-1:0] sram_data_in,
    output logic              sram_write_enable,
    output logic              sram_read_enable,
    output logic              busy,
    output logic              err_both
);

    logic              wr_s;
    logic              rd_s;
    seq_state_t        state_q, state_d;
    lat_cnt_t          cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    req_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
        .clk  (clk),
        .aclr (aclr),
        .d_i  (req_wr),
        .q_o  (wr_s)
    );

    req_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
        .clk  (clk),
        .aclr (aclr),
        .d_i  (req_rd),
        .q_o  (rd_s)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (wr_s) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    we_d    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                    err_d   = err_q | rd_s;
                end else if (rd_s) begin
                    addr_d  = req_addr;
                    re_d    = 1'b1;
                    cnt_d   = lat_cnt_t'(RD_LAT);
                    state_d = RD_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                // A count of 1 means sram_data_in is valid this cycle
                if (cnt_q <= lat_cnt_t'(1)) begin
                    rdata_d = sram_data_in;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - lat_cnt_t'(1);
                end
            end
            ACK: begin
                if (!wr_s && !rd_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (aclr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign ack               = ack_q;
    assign rsp_rdata         = rdata_q;
    assign sram_addr         = addr_q;
    assign sram_data_out     = wdata_q;
    assign sram_write_enable = we_q;
    assign sram_read_enable  = re_q;
    assign busy              = busy_q;
    assign err_both          = err_q;

endmodule

// File: tb/tb_sram_cmd_sequencer.sv
// Randomised handshake bench for sram_cmd_sequencer with a latency-based
// transaction model and a behavioural SRAM that drives garbage off-latency.
module tb_sram_cmd_sequencer;

    localparam int RD_LAT = 3;
    localparam int SYNC   = 2;

    logic        clk = 1'b0;
    logic        aclr;
    logic        req_wr, req_rd;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        ack;
    logic [7:0]  rsp_rdata;
    logic [15:0] sram_addr;
    logic [7:0]  sram_data_out;
    logic [7:0]  sram_data_in;
    logic        sram_write_enable, sram_read_enable;
    logic        busy, err_both;

    int total = 0;
    int bad   = 0;

    logic [7:0]  sram_mem [256];
    logic [7:0]  exp_mem  [256];
    logic [7:0]  re_hist;
    logic [8:0]  rd_vec;
    logic        pre_en;
    logic [15:0] pre_a;
    logic [7:0]  pre_d;
    logic [7:0]  exp_last;
    logic        exp_err;
    logic [15:0] written[$];

    always #5 clk = ~clk;

    sram_cmd_sequencer #(
        .ADDR_W(16), .DATA_W(8), .RD_LAT(RD_LAT), .SYNC_STAGES(SYNC)
    ) dut (
        .clk               (clk),
        .aclr              (aclr),
        .req_wr            (req_wr),
        .req_rd            (req_rd),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .ack               (ack),
        .rsp_rdata         (rsp_rdata),
        .sram_addr         (sram_addr),
        .sram_data_out     (sram_data_out),
        .sram_data_in      (sram_data_in),
        .sram_write_enable (sram_write_enable),
        .sram_read_enable  (sram_read_enable),
        .busy              (busy),
        .err_both          (err_both)
    );

    // Behavioural SRAM: data valid only RD_LAT-1 cycles after the read strobe
    always @(posedge clk) begin
        re_hist <= {re_hist[6:0], sram_read_enable};
        if (pre_en) sram_mem[pre_a[7:0]] <= pre_d;
        else if (sram_write_enable) sram_mem[sram_addr[7:0]] <= sram_data_out;
    end

    always_comb begin
        rd_vec       = {re_hist, sram_read_enable};
        sram_data_in = rd_vec[RD_LAT-1] ? sram_mem[sram_addr[7:0]] : 8'hFF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".ack"},   32'(ack), 32'd0);
        chk({tag, ".rdata"}, 32'(rsp_rdata), 32'd0);
        chk({tag, ".addr"},  32'(sram_addr), 32'd0);
        chk({tag, ".dout"},  32'(sram_data_out), 32'd0);
        chk({tag, ".strb"},  32'({sram_write_enable, sram_read_enable}), 32'd0);
        chk({tag, ".busy"},  32'(busy), 32'd0);
        chk({tag, ".err"},   32'(err_both), 32'd0);
    endtask

    // One handshake; request dropped at cycle max(ack, hold) or at cycle 1 if early
    task automatic run_txn(input logic wr, input logic rd, input logic [15:0] a,
                           input logic [7:0] d, input int hold, input bit early,
                           input string tag);
        int  we_cnt = 0, re_cnt = 0, both = 0, ack_hi = 0;
        int  strobe_at = 0, ack_at = 0, fall_at = 0, drop_n = 0;
        int  exp_ack, exp_drop, exp_fall;
        bit  is_wr, is_rd, dropped = 1'b0;
        logic [15:0] addr_at = '0;
        logic [7:0]  dout_at = '0, rdata_at = '0, exp_rd;
        logic        busy_at = 1'b0;
        is_wr = wr;
        is_rd = rd && !wr;
        req_addr = a; req_wdata = d; req_wr = wr; req_rd = rd;
        for (int n = 1; n <= 120 && fall_at == 0; n++) begin
            @(negedge clk);
            if ((sram_write_enable || sram_read_enable) && strobe_at == 0) begin
                strobe_at = n; addr_at = sram_addr; dout_at = sram_data_out; busy_at = busy;
            end
            we_cnt += int'(sram_write_enable);
            re_cnt += int'(sram_read_enable);
            both   += int'(sram_write_enable & sram_read_enable);
            if (ack && ack_at == 0) begin ack_at = n; rdata_at = rsp_rdata; end
            if (ack) ack_hi++;
            if (ack_at != 0 && !ack && fall_at == 0) fall_at = n;
            if (!dropped && ((early && n == 1) || (!early && ack_at != 0 && n >= hold))) begin
                dropped = 1'b1; drop_n = n; req_wr = 1'b0; req_rd = 1'b0;
            end
        end
        req_wr = 1'b0; req_rd = 1'b0;
        exp_ack  = is_rd ? SYNC + 1 + RD_LAT : SYNC + 1;
        exp_drop = early ? 1 : (hold > exp_ack ? hold : exp_ack);
        exp_fall = (exp_ack + 1 > exp_drop + SYNC + 1) ? exp_ack + 1 : exp_drop + SYNC + 1;
        exp_rd   = is_rd ? exp_mem[a[7:0]] : exp_last;
        chk({tag, ".strobe_at"}, 32'(strobe_at), 32'(SYNC + 1));
        chk({tag, ".we_cnt"},    32'(we_cnt), 32'(is_wr));
        chk({tag, ".re_cnt"},    32'(re_cnt), 32'(is_rd));
        chk({tag, ".both_hi"},   32'(both), 32'd0);
        chk({tag, ".addr"},      32'(addr_at), 32'(a));
        if (is_wr) chk({tag, ".wdata"}, 32'(dout_at), 32'(d));
        chk({tag, ".busy"},      32'(busy_at), 32'd1);
        chk({tag, ".ack_at"},    32'(ack_at), 32'(exp_ack));
        chk({tag, ".drop_at"},   32'(drop_n), 32'(exp_drop));
        chk({tag, ".fall_at"},   32'(fall_at), 32'(exp_fall));
        chk({tag, ".ack_len"},   32'(ack_hi), 32'(exp_fall - exp_ack));
        chk({tag, ".rdata"},     32'(rdata_at), 32'(exp_rd));
        exp_last = exp_rd;
        if (is_wr) begin
            exp_mem[a[7:0]] = d;
            written.push_back(a);
        end
        exp_err = exp_err | (wr & rd);
        chk({tag, ".err_both"},  32'(err_both), 32'(exp_err));
        chk({tag, ".idle"},      32'(busy), 32'd0);
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    initial begin
        int kind, hold;
        bit early;
        logic [15:0] a;
        aclr = 1'b1; req_wr = 1'b0; req_rd = 1'b0; req_addr = '0; req_wdata = '0;
        pre_en = 1'b0; pre_a = '0; pre_d = '0;
        exp_last = 8'h00; exp_err = 1'b0;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        // Clear the behavioural SRAM so both memories start equal
        for (int i = 0; i < 256; i++) begin
            pre_a = 16'(i); pre_d = 8'h00; pre_en = 1'b1;
            @(negedge clk);
        end
        pre_en = 1'b0;
        aclr = 1'b0;
        @(negedge clk);

        run_txn(1'b1, 1'b0, 16'h0010, 8'hA5, 1, 1'b0, "write");
        pre_a = 16'h0010; pre_d = 8'h3C; pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
        exp_mem[8'h10] = 8'h3C;
        run_txn(1'b0, 1'b1, 16'h0010, 8'h00, 1, 1'b0, "read");
        run_txn(1'b1, 1'b1, 16'h0002, 8'h11, 1, 1'b0, "both");
        run_txn(1'b1, 1'b0, 16'hBEEF, 8'h5A, 50, 1'b0, "held");
        run_txn(1'b1, 1'b0, 16'h0003, 8'h77, 1, 1'b1, "early_wr");
        run_txn(1'b0, 1'b1, 16'hBEEF, 8'h00, 1, 1'b1, "early_rd");

        // Abort a read in RD_WAIT, keep the request high, expect a clean re-issue
        req_addr = 16'h0010; req_rd = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        aclr = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rst");
        exp_err = 1'b0; exp_last = 8'h00;
        aclr = 1'b0;
        run_txn(1'b0, 1'b1, 16'h0010, 8'h00, 1, 1'b0, "reread");

        for (int t = 0; t < 25; t++) begin
            kind  = int'($urandom_range(0, 9));
            early = ($urandom_range(0, 4) == 0);
            hold  = int'($urandom_range(1, 8));
            if (kind < 5 || written.size() == 0) begin
                run_txn(1'b1, 1'b0, 16'($urandom), 8'($urandom), hold, early, "rnd_wr");
            end else if (kind < 9) begin
                a = written[$urandom_range(0, written.size() - 1)];
                run_txn(1'b0, 1'b1, a, 8'($urandom), hold, early, "rnd_rd");
            end else begin
                run_txn(1'b1, 1'b1, 16'($urandom), 8'($urandom), hold, early, "rnd_both");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_cmd_sequencer.md
Name: sram_cmd_sequencer

Overview:
- Sits between the JTAG virtual-interface stage and the `sram` block, in the system `clk` domain.
- Accepts single-word write and read requests from the JTAG side over a 4-phase req/ack handshake. Request levels arrive from the tck domain, so they are synchronised inside this block.
- Issues exactly one single-cycle `sram_write_enable` or `sram_read_enable` pulse per request, then returns read data.
- Owns the SRAM enable pulses, so no external pulse-clearing logic is needed.

Parameters:
- ADDR_W, 16, SRAM address width.
- DATA_W, 8, SRAM data width.
- RD_LAT, 1, cycles from the `sram_read_enable` pulse to valid `sram_data_in`; legal range 1..7.
- SYNC_STAGES, 2, flops in each request synchroniser; legal range 2..3.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- aclr  in  1  synchronous, active-high reset.
- req_wr  in  1  write request level, tck domain, asynchronous to clk.
- req_rd  in  1  read request level, tck domain, asynchronous to clk.
- req_addr  in  ADDR_W  request address; stable while any request is high.
- req_wdata  in  DATA_W  write data; stable while `req_wr` is high.
- ack  out  1  handshake acknowledge level.
- rsp_rdata  out  DATA_W  read result; valid while `ack` is high after a read.
- sram_addr  out  ADDR_W  SRAM address.
- sram_data_out  out  DATA_W  SRAM write data.
- sram_data_in  in  DATA_W  SRAM read data.
- sram_write_enable  out  1  one-cycle write strobe.
- sram_read_enable  out  1  one-cycle read strobe.
- busy  out  1  high whenever state is not IDLE.
- err_both  out  1  sticky flag: both requests were seen high together.

Behaviour:
- Reset (`aclr`=1 at a rising edge):
  - State goes to IDLE; synchronisers and the latency counter clear.
  - All outputs go to 0, including `rsp_rdata`, `sram_addr`, `sram_data_out` and `err_both`.
  - Reset mid-transaction aborts it with no further strobe.
  - A request still high after reset is serviced once, because requests are level-based.
- Synchronisation: `req_wr` and `req_rd` each pass through SYNC_STAGES flops, giving `wr_s` and `rd_s`. `req_addr` and `req_wdata` are sampled only in IDLE, after the synchronised request is seen; the handshake guarantees they are stable by then.
- All outputs are registered.
- State machine:
  - IDLE:
    - If `wr_s`: latch `sram_addr` ← `req_addr`, `sram_data_out` ← `req_wdata`, `sram_write_enable` ← 1. Go to ACK and set `ack` ← 1 on the same edge.
    - Else if `rd_s`: latch `sram_addr`, set `sram_read_enable` ← 1, load the counter with RD_LAT. Go to RD_WAIT.
    - If `wr_s` and `rd_s` are both high: write wins, `err_both` ← 1 (sticky until reset), and the read is not performed.
  - RD_WAIT:
    - Strobes are forced to 0; the counter decrements each cycle.
    - When the counter is 1: `rsp_rdata` ← `sram_data_in`, `ack` ← 1, go to ACK.
  - ACK:
    - Strobes are 0; `ack` holds 1.
    - When `wr_s`=0 and `rd_s`=0: `ack` ← 0, go to IDLE.
    - Neither request is re-serviced while in ACK.
- Strobe width: every enable is high for exactly one clk cycle per transaction. Enables are never high together.
- Latency, counted from the first clk edge sampling the request high (SYNC_STAGES=2):
  - Write: strobe at edge 3, `ack` at edge 3.
  - Read: strobe at edge 3, `ack` and `rsp_rdata` at edge 3+RD_LAT.
- Request dropped early (requester deasserts before `ack`):
  - The transaction still completes.
  - `ack` pulses for at least 1 cycle, then returns to IDLE.
- `rsp_rdata` holds its last read value across writes and until the next read completes.
- No address wrap logic: the address passes through unchanged.

Decomposition:
- Package `sram_cmd_pkg`:
  - state enum `seq_state_t` {IDLE, RD_WAIT, ACK};
  - default constants ADDR_W_DEF=16, DATA_W_DEF=8;
  - `lat_cnt_t` as 3-bit logic.
- One sub-module `req_sync`: a parameterised SYNC_STAGES flop chain with synchronous reset, instantiated twice (`req_wr`, `req_rd`).

Test Plan:
- Write handshake: `req_wr`=1, addr 0x0010, wdata 0xA5. Expect `sram_write_enable` high for exactly 1 cycle with `sram_addr`=0x0010 and `sram_data_out`=0xA5. `ack` rises the same edge. Drop `req_wr` → `ack` falls 2 cycles + 1 later.
- Read with RD_LAT=1: preload the SRAM model with 0x3C at 0x0010, `req_rd`=1. Expect one `sram_read_enable` pulse, then `rsp_rdata`=0x3C with `ack` one cycle later.
- Read with RD_LAT=3: `rsp_rdata` is captured exactly 3 cycles after the strobe. The value at the strobe+1 cycle is ignored (model drives 0xFF garbage there).
- Simultaneous request: `req_wr`=`req_rd`=1, addr 0x0002, wdata 0x11. Expect a write only, no read strobe, `err_both`=1 remaining high after the handshake ends.
- Held request: `req_wr` held high 50 cycles. Expect exactly one write strobe; `ack` stays 1 for the whole time.
- Reset mid-read: assert `aclr` in RD_WAIT (RD_LAT=3). All outputs read 0 next cycle, no `ack`. Request still high → the read is re-issued after reset and completes normally.
